// File: rtl/barrier_sequencer.sv
// Exit barrier motor sequencer: raises on open_req, holds until sensor3 clears, lowers against lim_dn.
// Optional BARRIER_REOPEN_EN: obstruction while closing reopens the gate instead of pausing it.
module barrier_sequencer #(
  parameter int CW        = 16,
  parameter int OPEN_TMO  = 500,
  parameter int HOLD_CYC  = 2000,
  parameter int CLOSE_TMO = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic open_req,
  input  logic lim_up,
  input  logic lim_dn,
  input  logic sensor3,
  input  logic fault_clr,
  output logic motor_up,
  output logic motor_dn,
  output logic gate_open,
  output logic busy,
  output logic passed,
  output logic fault
);

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING,
    ST_FAULT
  } state_t;

  localparam logic [CW-1:0] OPEN_LAST  = CW'(OPEN_TMO - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_TMO - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic            seen, seen_n;
  logic            s3_q;
  logic            passed_q, passed_n;
  logic            lim_both;
  logic            vehicle_exit;

`ifndef BARRIER_REOPEN_EN
  // hold marks a paused close: motor_dn is held off while sensor3 was high
  logic            hold, hold_n;
`endif

  assign lim_both     = lim_up && lim_dn;
  assign vehicle_exit = seen && s3_q && !sensor3;
  assign cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLOSED;
      cnt      <= '0;
      seen     <= 1'b0;
      s3_q     <= 1'b0;
      passed_q <= 1'b0;
`ifndef BARRIER_REOPEN_EN
      hold     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      seen     <= seen_n;
      s3_q     <= sensor3;
      passed_q <= passed_n;
`ifndef BARRIER_REOPEN_EN
      hold     <= hold_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    seen_n   = seen;
    passed_n = 1'b0;
    case (state)
      ST_CLOSED: begin
        if (lim_both) begin
          state_n = ST_FAULT;
        end else if (open_req) begin
          state_n = ST_OPENING;
          cnt_n   = '0;
        end
      end
      ST_OPENING: begin
        if (lim_both) begin
          state_n = ST_FAULT;
        end else if (lim_up) begin
          state_n = ST_OPEN;
          cnt_n   = '0;
          seen_n  = 1'b0;
        end else if (cnt == OPEN_LAST) begin
          state_n = ST_FAULT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_OPEN: begin
        if (sensor3) seen_n = 1'b1;
        if (lim_both) begin
          state_n = ST_FAULT;
        end else if (vehicle_exit) begin
          passed_n = 1'b1;
          cnt_n    = '0;
          if (open_req) seen_n = 1'b0;
          else          state_n = ST_CLOSING;
        end else if (open_req) begin
          cnt_n = '0;
        end else if (sensor3) begin
          cnt_n = cnt;   // never time out with a vehicle under the boom
        end else if (cnt == HOLD_LAST) begin
          state_n = ST_CLOSING;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_CLOSING: begin
        if (lim_both) begin
          state_n = ST_FAULT;
        end else if (lim_dn) begin
          state_n = ST_CLOSED;
        end else if (open_req) begin
          state_n = ST_OPENING;
          cnt_n   = '0;
        end else if (sensor3) begin
`ifdef BARRIER_REOPEN_EN
          state_n = ST_OPENING;
          cnt_n   = '0;
`else
          cnt_n   = cnt;
`endif
        end else if (cnt == CLOSE_LAST) begin
          state_n = ST_FAULT;
        end else if (motor_dn) begin
          cnt_n = cnt_inc;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          if (lim_dn) begin
            state_n = ST_CLOSED;
          end else begin
            state_n = ST_CLOSING;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_CLOSED;
        cnt_n   = '0;
      end
    endcase
  end

`ifndef BARRIER_REOPEN_EN
  always_comb begin
    hold_n = (state_n == ST_CLOSING) && sensor3;
  end
  assign motor_dn = (state == ST_CLOSING) && !hold;
`else
  assign motor_dn = (state == ST_CLOSING);
`endif

  // Outputs decode registered state only, so reset drops the motors at once
  assign motor_up  = (state == ST_OPENING);
  assign gate_open = (state == ST_OPEN);
  assign busy      = (state != ST_CLOSED);
  assign fault     = (state == ST_FAULT);
  assign passed    = passed_q;

endmodule

// File: tb/tb_barrier_sequencer.sv
// Directed bench for barrier_sequencer with OPEN_TMO=8, HOLD_CYC=10, CLOSE_TMO=8.
module tb_barrier_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic open_req, lim_up, lim_dn, sensor3, fault_clr;
  logic motor_up, motor_dn, gate_open, busy, passed, fault;

  int checks = 0;
  int errors = 0;

  barrier_sequencer #(
    .CW(16), .OPEN_TMO(8), .HOLD_CYC(10), .CLOSE_TMO(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .open_req(open_req), .lim_up(lim_up),
    .lim_dn(lim_dn), .sensor3(sensor3), .fault_clr(fault_clr),
    .motor_up(motor_up), .motor_dn(motor_dn), .gate_open(gate_open),
    .busy(busy), .passed(passed), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; open_req = 1'b0; lim_up = 1'b0; lim_dn = 1'b0;
    sensor3 = 1'b0; fault_clr = 1'b0;
    #2;
    chk("rst_motor_up", motor_up, 1'b0);
    chk("rst_motor_dn", motor_dn, 1'b0);
    chk("rst_gate_open", gate_open, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_passed", passed, 1'b0);
    chk("rst_fault", fault, 1'b0);
    #10 reset_n = 1'b1;
    lim_dn = 1'b1;
    tick();

    // Normal pass
    open_req = 1'b1; tick();                       // c1
    open_req = 1'b0; lim_dn = 1'b0;
    chk("np_up_c1", motor_up, 1'b1);
    chk("np_busy_c1", busy, 1'b1);
    repeat (3) tick();                             // c4
    chk("np_up_c4", motor_up, 1'b1);
    lim_up = 1'b1; tick();                         // c5
    chk("np_up_off_c5", motor_up, 1'b0);
    chk("np_open_c5", gate_open, 1'b1);
    repeat (2) tick();                             // c7
    sensor3 = 1'b1; repeat (3) tick();             // c10
    sensor3 = 1'b0;
    chk("np_open_c10", gate_open, 1'b1);
    chk("np_nopass_c10", passed, 1'b0);
    tick();                                        // c11
    chk("np_pass_c11", passed, 1'b1);
    chk("np_dn_c11", motor_dn, 1'b1);
    chk("np_open_off_c11", gate_open, 1'b0);
    lim_up = 1'b0; tick();                         // c12
    chk("np_pass_off_c12", passed, 1'b0);
    tick();                                        // c13
    lim_dn = 1'b1; tick();                         // c14
    chk("np_closed_busy", busy, 1'b0);
    chk("np_closed_dn", motor_dn, 1'b0);

    // Hold timeout, then obstruction during the resulting close
    open_req = 1'b1; tick();                       // c1
    open_req = 1'b0; lim_dn = 1'b0; tick();        // c2
    lim_up = 1'b1; tick();                         // c3: OPEN
    chk("ht_open_c3", gate_open, 1'b1);
    repeat (9) tick();                             // c12
    chk("ht_open_c12", gate_open, 1'b1);
    tick();                                        // c13
    chk("ht_closing_c13", motor_dn, 1'b1);
    chk("ht_nopass_c13", passed, 1'b0);
    lim_up = 1'b0;
    sensor3 = 1'b1; tick();                        // k1
`ifdef BARRIER_REOPEN_EN
    chk("ob_reopen_up", motor_up, 1'b1);
    chk("ob_reopen_dn", motor_dn, 1'b0);
    sensor3 = 1'b0; lim_up = 1'b1; tick();         // k2: OPEN
    chk("ob_reopen_open", gate_open, 1'b1);
    lim_up = 1'b0;
    repeat (10) tick();
    chk("ob_reopen_close", motor_dn, 1'b1);
    lim_dn = 1'b1; tick();
    chk("ob_reopen_closed", busy, 1'b0);
`else
    chk("ob_pause_dn_k1", motor_dn, 1'b0);
    chk("ob_pause_busy_k1", busy, 1'b1);
    tick();                                        // k2
    sensor3 = 1'b0;
    chk("ob_pause_dn_k2", motor_dn, 1'b0);
    tick();                                        // k3
    chk("ob_resume_k3", motor_dn, 1'b1);
    repeat (7) tick();                             // k10
    chk("ob_nofault_k10", fault, 1'b0);
    chk("ob_dn_k10", motor_dn, 1'b1);
    tick();                                        // k11
    chk("ct_fault_k11", fault, 1'b1);
    chk("ct_fault_dn", motor_dn, 1'b0);
    chk("ct_fault_up", motor_up, 1'b0);
    lim_dn = 1'b1; fault_clr = 1'b1; tick();
    fault_clr = 1'b0;
    chk("ct_clr_closed", busy, 1'b0);
    chk("ct_clr_fault", fault, 1'b0);
`endif

    // Open timeout
    open_req = 1'b1; tick();                       // c1
    open_req = 1'b0; lim_dn = 1'b0;
    repeat (7) tick();                             // c8
    chk("ot_up_c8", motor_up, 1'b1);
    chk("ot_nofault_c8", fault, 1'b0);
    tick();                                        // c9
    chk("ot_fault_c9", fault, 1'b1);
    chk("ot_up_off", motor_up, 1'b0);
    chk("ot_dn_off", motor_dn, 1'b0);
    chk("ot_busy", busy, 1'b1);
    fault_clr = 1'b1; tick();                      // c10
    fault_clr = 1'b0;
    chk("ot_clr_closing", motor_dn, 1'b1);
    chk("ot_clr_fault", fault, 1'b0);
    lim_dn = 1'b1; tick();
    chk("ot_closed", busy, 1'b0);

    // Back-to-back vehicles
    open_req = 1'b1; tick();                       // c1
    open_req = 1'b0; lim_dn = 1'b0; lim_up = 1'b1; tick();  // c2: OPEN
    chk("bb_open_c2", gate_open, 1'b1);
    repeat (5) tick();                             // c7
    sensor3 = 1'b1; tick();                        // c8
    sensor3 = 1'b0; open_req = 1'b1; tick();       // c9
    open_req = 1'b0;
    chk("bb_pass_c9", passed, 1'b1);
    chk("bb_stay_open_c9", gate_open, 1'b1);
    chk("bb_no_dn_c9", motor_dn, 1'b0);
    tick();                                        // c10
    chk("bb_pass_once", passed, 1'b0);
    repeat (8) tick();                             // c18
    chk("bb_hold_c18", gate_open, 1'b1);
    tick();                                        // c19
    chk("bb_close_c19", motor_dn, 1'b1);
    chk("bb_close_nopass", passed, 1'b0);
    lim_up = 1'b0; lim_dn = 1'b1; tick();
    chk("bb_closed", busy, 1'b0);

    // Both limit switches in OPENING
    open_req = 1'b1; tick();                       // c1
    open_req = 1'b0; lim_up = 1'b1; tick();        // c2
    chk("lf_fault", fault, 1'b1);
    chk("lf_up_off", motor_up, 1'b0);
    fault_clr = 1'b1; lim_up = 1'b0; tick();
    fault_clr = 1'b0;
    chk("lf_clr_closed", busy, 1'b0);

    // Asynchronous reset mid-OPENING
    open_req = 1'b1; tick();
    open_req = 1'b0; lim_dn = 1'b0; tick();
    chk("ar_up_before", motor_up, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_up", motor_up, 1'b0);
    chk("ar_dn", motor_dn, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_open", gate_open, 1'b0);
    chk("ar_fault", fault, 1'b0);
    chk("ar_passed", passed, 1'b0);
    #2 reset_n = 1'b1;
    tick();
    chk("ar_closed_busy", busy, 1'b0);
    chk("ar_closed_up", motor_up, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
